// File: rtl/irq_sched_pkg.sv
// Shared definitions for the interrupt scheduler slice.
// Holds the default source count / index width (matched to the EIB irq
// vector), the default priority width, and the scheduler state encoding.
package irq_sched_pkg;

  localparam int unsigned IRQ_COUNT = 32;
  localparam int unsigned ID_BITS   = 5;
  localparam int unsigned PRIO_BITS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational priority picker.
// Ports:
//   eligible_i : one bit per source, 1 = may be picked
//   prio_i     : flattened per-source priorities, source i at [i*PRIO_BITS +: PRIO_BITS]
//   id_o       : index of the winner (highest priority, lowest index on ties)
//   valid_o    : 1 when any source is eligible
module irq_prio_pick #(
  parameter int unsigned IRQ_COUNT = irq_sched_pkg::IRQ_COUNT,
  parameter int unsigned ID_BITS   = irq_sched_pkg::ID_BITS,
  parameter int unsigned PRIO_BITS = irq_sched_pkg::PRIO_BITS
) (
  input  logic [IRQ_COUNT-1:0]           eligible_i,
  input  logic [IRQ_COUNT*PRIO_BITS-1:0] prio_i,
  output logic [ID_BITS-1:0]             id_o,
  output logic                           valid_o
);
  import irq_sched_pkg::*;

  localparam int unsigned LEVELS = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
  localparam int unsigned LEAVES = 1 << LEVELS;
  localparam int unsigned NODES  = 2 * LEAVES - 1;

  // Heap-ordered binary tree: node n has children 2n+1 (lower indices) and
  // 2n+2 (higher indices); leaves sit at LEAVES-1 .. NODES-1.
  logic                 node_v  [NODES];
  logic [PRIO_BITS-1:0] node_p  [NODES];
  logic [ID_BITS-1:0]   node_id [NODES];
  int unsigned          n_idx;

  always_comb begin
    n_idx = 0;
    for (int unsigned j = 0; j < NODES; j++) begin
      node_v[j]  = 1'b0;
      node_p[j]  = '0;
      node_id[j] = '0;
    end
    for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
      node_v[LEAVES-1+i]  = eligible_i[i];
      node_p[LEAVES-1+i]  = prio_i[i*PRIO_BITS +: PRIO_BITS];
      node_id[LEAVES-1+i] = ID_BITS'(i);
    end
    // Bottom-up walk so both children are resolved before their parent.
    // The right child only wins on a strictly higher priority, which keeps
    // ties with the lower index.
    for (int unsigned j = 0; j < LEAVES - 1; j++) begin
      n_idx = LEAVES - 2 - j;
      if (node_v[2*n_idx+2] &&
          (!node_v[2*n_idx+1] || (node_p[2*n_idx+2] > node_p[2*n_idx+1]))) begin
        node_v[n_idx]  = 1'b1;
        node_p[n_idx]  = node_p[2*n_idx+2];
        node_id[n_idx] = node_id[2*n_idx+2];
      end else begin
        node_v[n_idx]  = node_v[2*n_idx+1];
        node_p[n_idx]  = node_p[2*n_idx+1];
        node_id[n_idx] = node_id[2*n_idx+1];
      end
    end
  end

  assign id_o    = node_id[0];
  assign valid_o = node_v[0];

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler feeding the EIB irq inputs.
// Latches per-source requests (edge or level mode), masks with enables,
// picks one winner by priority, delivers it as a one-cycle one-hot pulse and
// then holds off until the core acknowledges it.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   src          : raw peripheral requests (synchronous to clk)
//   cfg_we/idx/en/edge/prio : per-source configuration write
//   irq_out      : one-hot single-cycle pulse to the EIB
//   busy         : an interrupt is in flight awaiting ack
//   cur_id       : index of the in-flight / last issued source
//   ack          : single-cycle acknowledge of the in-flight interrupt
module irq_sched #(
  parameter int unsigned IRQ_COUNT = irq_sched_pkg::IRQ_COUNT,
  parameter int unsigned ID_BITS   = irq_sched_pkg::ID_BITS,
  parameter int unsigned PRIO_BITS = irq_sched_pkg::PRIO_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IRQ_COUNT-1:0] src,
  input  logic                 cfg_we,
  input  logic [ID_BITS-1:0]   cfg_idx,
  input  logic                 cfg_en,
  input  logic                 cfg_edge,
  input  logic [PRIO_BITS-1:0] cfg_prio,
  output logic [IRQ_COUNT-1:0] irq_out,
  output logic                 busy,
  output logic [ID_BITS-1:0]   cur_id,
  input  logic                 ack
);
  import irq_sched_pkg::*;

  state_e                         state_q, state_d;
  logic [IRQ_COUNT-1:0]           src_q;
  logic [IRQ_COUNT-1:0]           pending_q, pending_d;
  logic [IRQ_COUNT-1:0]           en_q, en_d;
  logic [IRQ_COUNT-1:0]           edge_q, edge_d;
  logic [IRQ_COUNT*PRIO_BITS-1:0] prio_q, prio_d;
  logic [ID_BITS-1:0]             sel_id_q, sel_id_d;
  logic [ID_BITS-1:0]             cur_id_q, cur_id_d;
  logic                           busy_q, busy_d;
  logic [IRQ_COUNT-1:0]           irq_out_q, irq_out_d;

  logic [IRQ_COUNT-1:0]           rise;
  logic [IRQ_COUNT-1:0]           eligible;
  logic [ID_BITS-1:0]             win_id;
  logic                           win_valid;

  assign rise = src & ~src_q;

  // Configuration table; indices with no matching source are dropped.
  always_comb begin
    en_d   = en_q;
    edge_d = edge_q;
    prio_d = prio_q;
    for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
      if (cfg_we && (cfg_idx == ID_BITS'(i))) begin
        en_d[i]                          = cfg_en;
        edge_d[i]                        = cfg_edge;
        prio_d[i*PRIO_BITS +: PRIO_BITS] = cfg_prio;
      end
    end
  end

  // Issue-clear is applied before the new-edge set so a coincident edge
  // survives; a disable is applied last so it always empties the bit.
  always_comb begin
    pending_d = pending_q;
    if ((state_q == ISSUE) && edge_q[sel_id_q]) begin
      pending_d[sel_id_q] = 1'b0;
    end
    pending_d = pending_d | (en_q & edge_q & rise);
    pending_d = pending_d & ~(edge_q & ~en_d);
  end

  // Level sources are taken from the registered copy of src so that both
  // modes see the same request-to-pulse latency.
  always_comb begin
    eligible = en_q & ((edge_q & pending_q) | (~edge_q & src_q));
    if (busy_q && !ack) begin
      eligible[cur_id_q] = 1'b0;
    end
  end

  irq_prio_pick #(
    .IRQ_COUNT (IRQ_COUNT),
    .ID_BITS   (ID_BITS),
    .PRIO_BITS (PRIO_BITS)
  ) u_pick (
    .eligible_i (eligible),
    .prio_i     (prio_q),
    .id_o       (win_id),
    .valid_o    (win_valid)
  );

  always_comb begin
    state_d   = state_q;
    sel_id_d  = sel_id_q;
    cur_id_d  = cur_id_q;
    busy_d    = busy_q;
    irq_out_d = '0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          sel_id_d = win_id;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        irq_out_d = {{(IRQ_COUNT-1){1'b0}}, 1'b1} << sel_id_q;
        cur_id_d  = sel_id_q;
        busy_d    = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        // The next winner is latched in the ack cycle itself, skipping IDLE.
        if (ack) begin
          busy_d = 1'b0;
          if (win_valid) begin
            sel_id_d = win_id;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      en_q      <= '0;
      edge_q    <= '0;
      prio_q    <= '0;
      sel_id_q  <= '0;
      cur_id_q  <= '0;
      busy_q    <= 1'b0;
      irq_out_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src;
      pending_q <= pending_d;
      en_q      <= en_d;
      edge_q    <= edge_d;
      prio_q    <= prio_d;
      sel_id_q  <= sel_id_d;
      cur_id_q  <= cur_id_d;
      busy_q    <= busy_d;
      irq_out_q <= irq_out_d;
    end
  end

  assign irq_out = irq_out_q;
  assign busy    = busy_q;
  assign cur_id  = cur_id_q;

endmodule
